// File: rtl/hazard_control_unit.sv
// hazard_control_unit: forwarding selects, load-use/redirect stall-flush control,
// data-RAM wait-state FSM and saturating stall/flush performance counters.
module hazard_control_unit #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_LATENCY = 0,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_memRead,
    input  logic                  ex_PCSrc,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  mem_regWrite,
    input  logic                  wb_regWrite,
    input  logic                  mem_access,
    input  logic                  clr_cnt,
    output logic [1:0]            fwdA,
    output logic [1:0]            fwdB,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_stall,
    output logic                  id_ex_flush,
    output logic                  ex_mem_stall,
    output logic                  mem_wb_bubble,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);
    typedef enum logic {IDLE, WAIT} state_t;

    localparam logic [7:0]       LAT      = 8'(MEM_LATENCY);
    localparam bit               HAS_WAIT = MEM_LATENCY > 0;
    localparam logic [CNT_W-1:0] ONE      = 1;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
    logic             lu, ms, redir, lu_eff;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (mem_regWrite && mem_rd != '0 && mem_rd == rs)
            return 2'b10;
        if (wb_regWrite && wb_rd != '0 && wb_rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        lu = ex_memRead && ex_rd != '0 &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
        ms      = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (mem_access && HAS_WAIT) begin
                ms      = 1'b1;
                cnt_d   = LAT - 8'd1;
                state_d = WAIT;
            end
            WAIT: if (cnt_q != 8'd0) begin
                ms    = 1'b1;
                cnt_d = cnt_q - 8'd1;
            end else begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // EX is frozen under a memory stall, so its redirect/load-use wait for release
        redir   = ex_PCSrc && !ms;
        lu_eff  = lu && !ms && !ex_PCSrc;
        stall_d = clr_cnt ? '0 : ((ms || lu_eff) && stall_q != '1) ? stall_q + ONE : stall_q;
        flush_d = clr_cnt ? '0 : (redir && flush_q != '1) ? flush_q + ONE : flush_q;
    end

    always_comb begin
        fwdA          = rst ? fwd_sel(ex_rs1) : 2'b00;
        fwdB          = rst ? fwd_sel(ex_rs2) : 2'b00;
        pc_stall      = rst && (ms || lu_eff);
        if_id_stall   = rst && (ms || lu_eff);
        if_id_flush   = rst && redir;
        id_ex_stall   = rst && ms;
        id_ex_flush   = rst && (redir || lu_eff);
        ex_mem_stall  = rst && ms;
        mem_wb_bubble = rst && ms;
        stall_cycles  = stall_q;
        flush_count   = flush_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed vectors plus multi-cycle sequences on a
// MEM_LATENCY=3 instance and a MEM_LATENCY=0 instance with 2-bit counters.
module tb_hazard_control_unit;
    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LU   = 7'b1100100;
    localparam logic [6:0] MS   = 7'b1101011;
    localparam logic [6:0] RD   = 7'b0010100;

    typedef struct {
        logic [4:0] ers1, ers2, mrd, wrd, irs1, irs2, erd;
        logic       mrw, wrw, u1, u2, mr, pc;
        logic [1:0] fa, fb;
        logic [6:0] ctl;
    } vec_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_memRead, ex_PCSrc, mem_regWrite, wb_regWrite;
    logic mem_access, clr_cnt;

    logic [1:0]  fa3, fb3, fa0, fb0;
    logic        ps3, iis3, iif3, ies3, ief3, ems3, mwb3;
    logic        ps0, iis0, iif0, ies0, ief0, ems0, mwb0;
    logic [31:0] sc3, fc3;
    logic [1:0]  sc0, fc0;
    logic [6:0]  ctl3, ctl0;

    int tests = 0, fails = 0;

    assign ctl3 = {ps3, iis3, iif3, ies3, ief3, ems3, mwb3};
    assign ctl0 = {ps0, iis0, iif0, ies0, ief0, ems0, mwb0};

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_ADDR_W(5), .MEM_LATENCY(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_PCSrc(ex_PCSrc), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .mem_access(mem_access), .clr_cnt(clr_cnt), .fwdA(fa3), .fwdB(fb3),
        .pc_stall(ps3), .if_id_stall(iis3), .if_id_flush(iif3), .id_ex_stall(ies3),
        .id_ex_flush(ief3), .ex_mem_stall(ems3), .mem_wb_bubble(mwb3),
        .stall_cycles(sc3), .flush_count(fc3)
    );

    hazard_control_unit #(.REG_ADDR_W(5), .MEM_LATENCY(0), .CNT_W(2)) dut0 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_memRead(ex_memRead), .ex_PCSrc(ex_PCSrc), .mem_rd(mem_rd),
        .wb_rd(wb_rd), .mem_regWrite(mem_regWrite), .wb_regWrite(wb_regWrite),
        .mem_access(mem_access), .clr_cnt(clr_cnt), .fwdA(fa0), .fwdB(fb0),
        .pc_stall(ps0), .if_id_stall(iis0), .if_id_flush(iif0), .id_ex_stall(ies0),
        .id_ex_flush(ief0), .ex_mem_stall(ems0), .mem_wb_bubble(mwb0),
        .stall_cycles(sc0), .flush_count(fc0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {id_use_rs1, id_use_rs2, ex_memRead, ex_PCSrc, mem_regWrite, wb_regWrite} = '0;
        mem_access = 1'b0;
        clr_cnt    = 1'b0;
    endtask

    task automatic set_lu();
        ex_memRead = 1'b1;
        ex_rd      = 5'd3;
        id_rs2     = 5'd3;
        id_use_rs2 = 1'b1;
    endtask

    function automatic vec_t mk(input logic [4:0] ers1, ers2, mrd, input logic mrw,
                                input logic [4:0] wrd, input logic wrw,
                                input logic [4:0] irs1, irs2, input logic u1, u2,
                                input logic [4:0] erd, input logic mr, pc,
                                input logic [1:0] fa, fb, input logic [6:0] ctl);
        vec_t v;
        v.ers1 = ers1; v.ers2 = ers2; v.mrd = mrd; v.mrw = mrw; v.wrd = wrd; v.wrw = wrw;
        v.irs1 = irs1; v.irs2 = irs2; v.u1 = u1; v.u2 = u2; v.erd = erd; v.mr = mr; v.pc = pc;
        v.fa = fa; v.fb = fb; v.ctl = ctl;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v[12];
        v[0]  = mk(5, 0, 5, 1, 5, 1,  0, 0, 0, 0,  0, 0, 0, 2'b10, 2'b00, NONE);
        v[1]  = mk(5, 0, 0, 1, 5, 1,  0, 0, 0, 0,  0, 0, 0, 2'b01, 2'b00, NONE);
        v[2]  = mk(5, 0, 0, 1, 0, 1,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b00, NONE);
        v[3]  = mk(7, 7, 7, 0, 7, 1,  0, 0, 0, 0,  0, 0, 0, 2'b01, 2'b01, NONE);
        v[4]  = mk(2, 9, 9, 1, 9, 1,  0, 0, 0, 0,  0, 0, 0, 2'b00, 2'b10, NONE);
        v[5]  = mk(0, 0, 0, 0, 0, 0,  0, 3, 0, 1,  3, 1, 0, 2'b00, 2'b00, LU);
        v[6]  = mk(0, 0, 0, 0, 0, 0,  0, 3, 0, 0,  3, 1, 0, 2'b00, 2'b00, NONE);
        v[7]  = mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0,  0, 1, 0, 2'b00, 2'b00, NONE);
        v[8]  = mk(0, 0, 0, 0, 0, 0,  4, 0, 1, 0,  4, 1, 0, 2'b00, 2'b00, LU);
        v[9]  = mk(0, 0, 0, 0, 0, 0,  4, 0, 1, 0,  4, 1, 1, 2'b00, 2'b00, RD);
        v[10] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 1, 2'b00, 2'b00, RD);
        v[11] = mk(0, 0, 0, 0, 0, 0,  4, 0, 1, 0,  4, 0, 0, 2'b00, 2'b00, NONE);

        idle_inputs();
        step();
        step();
        chk("reset ctl", 32'(ctl3), 32'(NONE));
        chk("reset stall_cycles", sc3, 0);
        chk("reset flush_count", fc3, 0);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            step();
            ex_rs1 = v[i].ers1; ex_rs2 = v[i].ers2; mem_rd = v[i].mrd; mem_regWrite = v[i].mrw;
            wb_rd = v[i].wrd; wb_regWrite = v[i].wrw; id_rs1 = v[i].irs1; id_rs2 = v[i].irs2;
            id_use_rs1 = v[i].u1; id_use_rs2 = v[i].u2; ex_rd = v[i].erd;
            ex_memRead = v[i].mr; ex_PCSrc = v[i].pc;
            #1;
            chk($sformatf("vec%0d fwdA", i), 32'(fa3), 32'(v[i].fa));
            chk($sformatf("vec%0d fwdB", i), 32'(fb3), 32'(v[i].fb));
            chk($sformatf("vec%0d ctl L3", i), 32'(ctl3), 32'(v[i].ctl));
            chk($sformatf("vec%0d ctl L0", i), 32'(ctl0), 32'(v[i].ctl));
        end

        // single load-use bubble and counter increment
        step(); idle_inputs(); clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0;
        #1 chk("lu cnt before", sc3, 0);
        set_lu();
        #1 chk("lu ctl", 32'(ctl3), 32'(LU));
        step(); idle_inputs();
        #1 chk("lu ctl after", 32'(ctl3), 32'(NONE));
        chk("lu cnt after", sc3, 1);

        // held access: three stall cycles then release
        clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0; mem_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("wait c%0d", k), 32'(ctl3), 32'(k < 3 ? MS : NONE));
            step();
        end
        mem_access = 1'b0;
        #1 chk("wait done ctl", 32'(ctl3), 32'(NONE));
        chk("wait stall_cycles", sc3, 3);

        // redirect during a wait acts only in the release cycle
        clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0; mem_access = 1'b1; ex_PCSrc = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("redir c%0d", k), 32'(ctl3), 32'(k < 3 ? MS : RD));
            step();
        end
        mem_access = 1'b0; ex_PCSrc = 1'b0;
        #1 chk("redir flush_count", fc3, 1);
        chk("redir stall_cycles", sc3, 3);

        // reset in the second wait cycle abandons the access
        step(); mem_access = 1'b1;
        #1 chk("rst c0", 32'(ctl3), 32'(MS));
        step();
        ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regWrite = 1'b1; rst = 1'b0;
        #1 chk("rst ctl", 32'(ctl3), 32'(NONE));
        chk("rst fwdA", 32'(fa3), 32'(2'b00));
        chk("rst stall_cycles", sc3, 0);
        chk("rst flush_count", fc3, 0);
        step(); rst = 1'b1; mem_access = 1'b0;
        #1 chk("post rst fwdA", 32'(fa3), 32'(2'b10));
        step(); idle_inputs(); mem_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("post rst c%0d", k), 32'(ctl3), 32'(k < 3 ? MS : NONE));
            step();
        end
        mem_access = 1'b0;
        #1 chk("post rst stall_cycles", sc3, 3);

        // zero latency: never stalls; clear beats increment; 2-bit saturation
        clr_cnt = 1'b1;
        step(); clr_cnt = 1'b0; mem_access = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("lat0 c%0d", k), 32'(ctl0), 32'(NONE));
            step();
        end
        mem_access = 1'b0;
        #1 chk("lat0 stall_cycles", 32'(sc0), 0);
        clr_cnt = 1'b1; set_lu();
        #1 chk("lat0 lu ctl", 32'(ctl0), 32'(LU));
        step(); clr_cnt = 1'b0;
        #1 chk("clr wins", 32'(sc0), 0);
        step();
        #1 chk("lu incr", 32'(sc0), 1);
        step(); step(); step();
        #1 chk("stall saturate", 32'(sc0), 3);
        idle_inputs(); ex_PCSrc = 1'b1;
        for (int k = 0; k < 5; k++) step();
        #1 chk("flush saturate", 32'(fc0), 3);
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
